// File: rtl/alu_rr_sched_if.sv
// Bundle of requester, ALU and response signals around the round-robin ALU scheduler.
// The slave modport is the scheduler side; the master modport is the client/ALU side.
interface alu_rr_sched_if #(
  parameter int N = 4,
  parameter int W = 4
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_op1;
  logic [N*W-1:0] req_op2;
  logic [N*3-1:0] req_opcode;
  logic [W-1:0]   alu_op1;
  logic [W-1:0]   alu_op2;
  logic [2:0]     alu_opcode;
  logic           alu_start;
  logic [W-1:0]   alu_result;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_data;

  modport slave (
    input  req_valid, req_op1, req_op2, req_opcode, alu_result, rsp_ready,
    output req_ready, alu_op1, alu_op2, alu_opcode, alu_start,
           rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req_valid, req_op1, req_op2, req_opcode, alu_result, rsp_ready,
    input  req_ready, alu_op1, alu_op2, alu_opcode, alu_start,
           rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one fixed-latency ALU among N requesters;
// one operation in flight, result returned tagged with the requester index.
module alu_rr_sched #(
  parameter int N       = 4,
  parameter int W       = 4,
  parameter int ALU_LAT = 1
) (
  input  logic           clk,
  input  logic           rstn,
  alu_rr_sched_if.slave  bus,
  output logic           busy
);
  localparam int IDW = $clog2(N);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t         state_r;
  state_t         next_state_s;
  logic [IDW-1:0] ptr_r;
  logic [2:0]     cnt_r;
  logic           busy_r;
  logic [W-1:0]   alu_op1_r;
  logic [W-1:0]   alu_op2_r;
  logic [2:0]     alu_opcode_r;
  logic           alu_start_r;
  logic           rsp_valid_r;
  logic [IDW-1:0] rsp_id_r;
  logic [W-1:0]   rsp_data_r;

  logic           found_s;
  logic [IDW-1:0] gidx_s;
  logic [IDW-1:0] idx_s;
  logic [N-1:0]   grant_s;
  logic [N-1:0]   ready_s;
  logic           accept_s;

  // Scan requesters starting at ptr_r, wrapping, and pick the first valid one.
  always_comb begin
    found_s = 1'b0;
    gidx_s  = '0;
    idx_s   = '0;
    for (int k = 0; k < N; k++) begin
      idx_s = IDW'((int'(ptr_r) + k) % N);
      if (!found_s && bus.req_valid[idx_s]) begin
        found_s = 1'b1;
        gidx_s  = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // One-hot ready, gated by rstn so reset forces it low even with requests pending.
  always_comb begin
    grant_s = '0;
    ready_s = '0;
    if (found_s) begin
      grant_s[gidx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
    if (rstn && (state_r == ST_IDLE)) begin
      ready_s = grant_s;
    end else begin
      ready_s = '0;
    end
  end

  assign accept_s = found_s && (state_r == ST_IDLE);

  // Next-state decode for IDLE -> EXEC -> RESP -> IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) next_state_s = ST_EXEC;
        else          next_state_s = ST_IDLE;
      end
      ST_EXEC: begin
        if (cnt_r == 3'd0) next_state_s = ST_RESP;
        else               next_state_s = ST_EXEC;
      end
      ST_RESP: begin
        if (bus.rsp_ready) next_state_s = ST_IDLE;
        else               next_state_s = ST_RESP;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register; busy is registered from the next state so it tracks state_r.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != ST_IDLE);
    end
  end

  // Operand capture, latency countdown, response capture and pointer advance.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_r        <= '0;
      cnt_r        <= 3'd0;
      alu_op1_r    <= '0;
      alu_op2_r    <= '0;
      alu_opcode_r <= 3'd0;
      alu_start_r  <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= '0;
      rsp_data_r   <= '0;
    end else begin
      alu_start_r <= accept_s;
      if (accept_s) begin
        alu_op1_r    <= bus.req_op1[int'(gidx_s)*W +: W];
        alu_op2_r    <= bus.req_op2[int'(gidx_s)*W +: W];
        alu_opcode_r <= bus.req_opcode[int'(gidx_s)*3 +: 3];
        rsp_id_r     <= gidx_s;
        cnt_r        <= 3'(ALU_LAT);
      end else if (state_r == ST_EXEC) begin
        if (cnt_r != 3'd0) begin
          cnt_r <= cnt_r - 3'd1;
        end else begin
          rsp_data_r  <= bus.alu_result;
          rsp_valid_r <= 1'b1;
        end
      end else if ((state_r == ST_RESP) && bus.rsp_ready) begin
        rsp_valid_r <= 1'b0;
        // Next scan starts just after the requester that was served.
        ptr_r <= (rsp_id_r == IDW'(N-1)) ? '0 : rsp_id_r + IDW'(1);
      end
    end
  end

  assign bus.req_ready  = ready_s;
  assign bus.alu_op1    = alu_op1_r;
  assign bus.alu_op2    = alu_op2_r;
  assign bus.alu_opcode = alu_opcode_r;
  assign bus.alu_start  = alu_start_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_id     = rsp_id_r;
  assign bus.rsp_data   = rsp_data_r;
  assign busy           = busy_r;
endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed bench for alu_rr_sched: ALU_LAT=1 main instance plus ALU_LAT=0/3 instances
// for latency checks; ALU stubs return a wrong value outside the valid-result cycle.
module tb_alu_rr_sched;
  logic clk;
  logic rstn;
  logic busy1, busy0, busy3;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cycn    = 0;

  alu_rr_sched_if #(.N(4), .W(4)) bus1 ();
  alu_rr_sched_if #(.N(4), .W(4)) x0 ();
  alu_rr_sched_if #(.N(4), .W(4)) x3 ();

  alu_rr_sched #(.N(4), .W(4), .ALU_LAT(1)) u1 (.clk(clk), .rstn(rstn), .bus(bus1), .busy(busy1));
  alu_rr_sched #(.N(4), .W(4), .ALU_LAT(0)) u0 (.clk(clk), .rstn(rstn), .bus(x0),   .busy(busy0));
  alu_rr_sched #(.N(4), .W(4), .ALU_LAT(3)) u3 (.clk(clk), .rstn(rstn), .bus(x3),   .busy(busy3));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycn <= cycn + 1;

  function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  // ALU stubs: correct result only in the cycle ALU_LAT after alu_start
  logic       v1_r = 1'b0;
  logic [2:0] v3_r = 3'd0;
  always @(posedge clk) begin
    v1_r <= bus1.alu_start;
    v3_r <= {v3_r[1:0], x3.alu_start};
  end
  assign bus1.alu_result = v1_r ? alu_f(bus1.alu_op1, bus1.alu_op2, bus1.alu_opcode)
                                : ~alu_f(bus1.alu_op1, bus1.alu_op2, bus1.alu_opcode);
  assign x0.alu_result   = x0.alu_start ? alu_f(x0.alu_op1, x0.alu_op2, x0.alu_opcode)
                                        : ~alu_f(x0.alu_op1, x0.alu_op2, x0.alu_opcode);
  assign x3.alu_result   = v3_r[2] ? alu_f(x3.alu_op1, x3.alu_op2, x3.alu_opcode)
                                   : ~alu_f(x3.alu_op1, x3.alu_op2, x3.alu_opcode);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic rst_chk(input string nm);
    chk(nm, {bus1.req_ready, bus1.alu_op1, bus1.alu_op2, bus1.alu_opcode, bus1.alu_start,
             bus1.rsp_valid, bus1.rsp_id, bus1.rsp_data, busy1}, 32'd0);
  endtask

  // One operation on the main instance; other requesters' operands are X.
  task automatic run_op(input int id, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] opc, input logic [3:0] expd, input logic [3:0] mask);
    int w;
    int cyc;
    bus1.req_valid  = mask;
    bus1.req_op1    = 'x;
    bus1.req_op2    = 'x;
    bus1.req_opcode = 'x;
    bus1.req_op1[id*4 +: 4]    = a;
    bus1.req_op2[id*4 +: 4]    = b;
    bus1.req_opcode[id*3 +: 3] = opc;
    #1;
    w = 0;
    while (bus1.req_ready == 4'd0 && w < 10) begin
      @(posedge clk); #1; w++;
    end
    chk("grant", bus1.req_ready, 32'd1 << id);
    @(posedge clk); #1;
    bus1.req_valid  = 4'd0;
    bus1.req_op1    = 'x;
    bus1.req_op2    = 'x;
    bus1.req_opcode = 'x;
    cyc = 1;
    while (!bus1.rsp_valid && cyc < 20) begin
      chk("alu_start pulse", bus1.alu_start, (cyc == 1));
      chk("alu_op1 hold", bus1.alu_op1, a);
      chk("exec req_ready", bus1.req_ready, 32'd0);
      @(posedge clk); #1; cyc++;
    end
    chk("latency", cyc, 32'd3);
    chk("rsp_id", bus1.rsp_id, id);
    chk("rsp_data", bus1.rsp_data, expd);
    chk("busy resp", busy1, 32'd1);
    if (bus1.rsp_ready) begin
      @(posedge clk); #1;
      chk("rsp_valid drop", bus1.rsp_valid, 32'd0);
    end else begin
      chk("rsp held", bus1.rsp_valid, 32'd1);
    end
  endtask

  typedef struct {
    int         id;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] opc;
    logic [3:0] expd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int w;
    int cyc;
    int prev;
    vecs[0] = '{2, 4'h3, 4'h4, 3'd0, 4'h7};
    vecs[1] = '{0, 4'h9, 4'h8, 3'd0, 4'h1};
    vecs[2] = '{1, 4'hA, 4'h3, 3'd1, 4'h7};
    vecs[3] = '{3, 4'hC, 4'hA, 3'd2, 4'h8};
    vecs[4] = '{0, 4'h5, 4'hF, 3'd4, 4'hA};
    vecs[5] = '{2, 4'h9, 4'h6, 3'd3, 4'hF};
    vecs[6] = '{1, 4'h2, 4'h5, 3'd1, 4'hD};
    vecs[7] = '{3, 4'h7, 4'h7, 3'd5, 4'h7};

    rstn = 1'b1;
    bus1.req_valid = 4'hF; bus1.req_op1 = 16'h1234; bus1.req_op2 = 16'h5678;
    bus1.req_opcode = 12'h0; bus1.rsp_ready = 1'b1;
    x0.req_valid = 4'h0; x0.req_op1 = 16'h0; x0.req_op2 = 16'h0; x0.req_opcode = 12'h0; x0.rsp_ready = 1'b1;
    x3.req_valid = 4'h0; x3.req_op1 = 16'h0; x3.req_op2 = 16'h0; x3.req_opcode = 12'h0; x3.rsp_ready = 1'b1;
    #2 rstn = 1'b0;
    #1 rst_chk("reset outputs");
    @(posedge clk); #1;
    rst_chk("reset held");
    bus1.req_valid = 4'h0;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Single-requester vectors
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].opc, vecs[i].expd, 4'd1 << vecs[i].id);

    // All four continuously valid; pointer is 0 after serving requester 3
    for (int i = 0; i < 4; i++) begin
      bus1.req_op1[i*4 +: 4]    = 4'(i);
      bus1.req_op2[i*4 +: 4]    = 4'(i + 1);
      bus1.req_opcode[i*3 +: 3] = 3'd0;
    end
    bus1.req_valid = 4'hF;
    #1;
    prev = 0;
    for (int k = 0; k < 8; k++) begin
      w = 0;
      while (bus1.req_ready == 4'd0 && w < 10) begin
        @(posedge clk); #1; w++;
      end
      chk("rr grant", bus1.req_ready, 32'd1 << (k % 4));
      if (k > 0) chk("accept spacing", cycn - prev, 32'd4);
      prev = cycn;
      w = 0;
      while (!bus1.rsp_valid && w < 10) begin
        @(posedge clk); #1; w++;
      end
      chk("rr rsp_id", bus1.rsp_id, k % 4);
      chk("rr rsp_data", bus1.rsp_data, 4'(2 * (k % 4) + 1));
    end
    bus1.req_valid = 4'h0;
    @(posedge clk); #1;

    // Back-pressure on the response
    bus1.rsp_ready = 1'b0;
    run_op(1, 4'h6, 4'h7, 3'd0, 4'hD, 4'b0010);
    bus1.req_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp rsp_valid", bus1.rsp_valid, 32'd1);
      chk("bp rsp_id", bus1.rsp_id, 32'd1);
      chk("bp rsp_data", bus1.rsp_data, 32'hD);
      chk("bp req_ready", bus1.req_ready, 32'd0);
      chk("bp busy", busy1, 32'd1);
      chk("bp alu_op1", bus1.alu_op1, 32'h6);
    end
    bus1.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release", bus1.rsp_valid, 32'd0);
    chk("bp idle busy", busy1, 32'd0);
    chk("bp next grant", bus1.req_ready, 32'b0100);
    bus1.req_valid = 4'h0;
    @(posedge clk); #1;
    chk("dropped request", busy1, 32'd0);

    // Wrap-around: ptr=3 after serving 2
    run_op(2, 4'h1, 4'h1, 3'd0, 4'h2, 4'b0100);
    run_op(3, 4'h4, 4'h4, 3'd0, 4'h8, 4'b1001);
    run_op(0, 4'h8, 4'h8, 3'd0, 4'h0, 4'b1001);

    // Reset during EXEC (ptr is 1 here)
    bus1.req_valid = 4'b0100;
    bus1.req_op1[8 +: 4] = 4'h5; bus1.req_op2[8 +: 4] = 4'h5; bus1.req_opcode[6 +: 3] = 3'd0;
    @(posedge clk); #2;
    chk("exec before reset", busy1, 32'd1);
    rstn = 1'b0;
    #1 rst_chk("async reset in exec");
    @(posedge clk); #1;
    rstn = 1'b1;
    bus1.req_valid = 4'h0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("no rsp after abort", bus1.rsp_valid, 32'd0);
    end
    bus1.req_valid = 4'hF;
    bus1.req_op1 = 16'h0; bus1.req_op2 = 16'h0; bus1.req_opcode = 12'h0;
    #1 chk("ptr after reset", bus1.req_ready, 32'b0001);
    bus1.req_valid = 4'h0;
    @(posedge clk); #1;

    // ALU_LAT=0 instance
    x0.req_valid = 4'b0010;
    x0.req_op1[4 +: 4] = 4'hA; x0.req_op2[4 +: 4] = 4'h3; x0.req_opcode[3 +: 3] = 3'd1;
    #1 chk("lat0 grant", x0.req_ready, 32'b0010);
    @(posedge clk); #1;
    x0.req_valid = 4'h0; x0.req_op1 = 'x; x0.req_op2 = 'x; x0.req_opcode = 'x;
    cyc = 1;
    while (!x0.rsp_valid && cyc < 20) begin
      chk("lat0 ops hold", {x0.alu_op1, x0.alu_op2, x0.alu_opcode}, {4'hA, 4'h3, 3'd1});
      @(posedge clk); #1; cyc++;
    end
    chk("lat0 latency", cyc, 32'd2);
    chk("lat0 rsp_id", x0.rsp_id, 32'd1);
    chk("lat0 rsp_data", x0.rsp_data, 32'h7);
    @(posedge clk); #1;

    // ALU_LAT=3 instance
    x3.req_valid = 4'b1000;
    x3.req_op1[12 +: 4] = 4'h9; x3.req_op2[12 +: 4] = 4'hC; x3.req_opcode[9 +: 3] = 3'd4;
    #1 chk("lat3 grant", x3.req_ready, 32'b1000);
    @(posedge clk); #1;
    x3.req_valid = 4'h0; x3.req_op1 = 'x; x3.req_op2 = 'x; x3.req_opcode = 'x;
    cyc = 1;
    while (!x3.rsp_valid && cyc < 20) begin
      chk("lat3 ops hold", {x3.alu_op1, x3.alu_op2, x3.alu_opcode}, {4'h9, 4'hC, 3'd4});
      chk("lat3 req_ready", x3.req_ready, 32'd0);
      @(posedge clk); #1; cyc++;
    end
    chk("lat3 latency", cyc, 32'd5);
    chk("lat3 rsp_id", x3.rsp_id, 32'd3);
    chk("lat3 rsp_data", x3.rsp_data, 32'h5);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
